// File: rtl/e1_rx_phy_mc.sv
// Multi-channel E1 receive line front end: per-line synchroniser, majority-vote
// glitch filter, hi/lo conflict detection with event count, and loss-of-signal.
module e1_rx_phy_mc #(
  parameter int NUM_CH      = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_TAPS   = 3,
  parameter int LOS_THRESH  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     pad_rx_hi,
  input  logic [NUM_CH-1:0]     pad_rx_lo,
  output logic [NUM_CH-1:0]     rx_hi,
  output logic [NUM_CH-1:0]     rx_lo,
  output logic [NUM_CH-1:0]     viol,
  output logic [8*NUM_CH-1:0]   viol_cnt,
  input  logic [NUM_CH-1:0]     viol_clr,
  output logic [NUM_CH-1:0]     los
);

  localparam logic [2:0]  MAJ_MIN = 3'((FILT_TAPS + 1) / 2);
  localparam logic [15:0] LOS_MAX = 16'(LOS_THRESH);

  logic [SYNC_STAGES-1:0] sync_hi_q [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_hi_d [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_lo_q [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_lo_d [NUM_CH];
  logic [FILT_TAPS-1:0]   win_hi_q  [NUM_CH];
  logic [FILT_TAPS-1:0]   win_hi_d  [NUM_CH];
  logic [FILT_TAPS-1:0]   win_lo_q  [NUM_CH];
  logic [FILT_TAPS-1:0]   win_lo_d  [NUM_CH];
  logic [7:0]             cnt_q     [NUM_CH];
  logic [7:0]             cnt_d     [NUM_CH];
  logic [15:0]            los_cnt_q [NUM_CH];
  logic [15:0]            los_cnt_d [NUM_CH];

  logic [NUM_CH-1:0] filt_hi, filt_lo;
  logic [NUM_CH-1:0] rx_hi_q, rx_hi_d, rx_lo_q, rx_lo_d;
  logic [NUM_CH-1:0] conf_q, conf_d, viol_q, viol_d, los_q, los_d;

  function automatic logic majority(input logic [FILT_TAPS-1:0] w);
    logic [2:0] ones;
    ones = '0;
    for (int i = 0; i < FILT_TAPS; i++) ones = ones + 3'(w[i]);
    return ones >= MAJ_MIN;
  endfunction

  always_comb begin
    filt_hi = '0;
    filt_lo = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      filt_hi[c] = majority(win_hi_q[c]);
      filt_lo[c] = majority(win_lo_q[c]);
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    conf_d  = filt_hi & filt_lo;
    rx_hi_d = filt_hi & ~filt_lo;
    rx_lo_d = filt_lo & ~filt_hi;
    viol_d  = conf_d & ~conf_q;
    los_d   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sync_hi_d[c]    = sync_hi_q[c] << 1;
      sync_hi_d[c][0] = pad_rx_hi[c];
      sync_lo_d[c]    = sync_lo_q[c] << 1;
      sync_lo_d[c][0] = pad_rx_lo[c];
      win_hi_d[c]     = win_hi_q[c] << 1;
      win_hi_d[c][0]  = sync_hi_q[c][SYNC_STAGES-1];
      win_lo_d[c]     = win_lo_q[c] << 1;
      win_lo_d[c][0]  = sync_lo_q[c][SYNC_STAGES-1];

      // A clear that lands on the pulse cycle still counts that pulse.
      cnt_d[c] = cnt_q[c];
      if (viol_clr[c])                         cnt_d[c] = {7'd0, viol_q[c]};
      else if (viol_q[c] && cnt_q[c] != 8'hFF) cnt_d[c] = cnt_q[c] + 8'd1;

      los_cnt_d[c] = los_cnt_q[c];
      if (rx_hi_q[c] || rx_lo_q[c])      los_cnt_d[c] = '0;
      else if (los_cnt_q[c] < LOS_MAX)   los_cnt_d[c] = los_cnt_q[c] + 16'd1;
      los_d[c] = (los_cnt_d[c] == LOS_MAX);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_hi_q <= '0;
      rx_lo_q <= '0;
      conf_q  <= '0;
      viol_q  <= '0;
      los_q   <= '1;
      for (int c = 0; c < NUM_CH; c++) begin
        sync_hi_q[c] <= '0;
        sync_lo_q[c] <= '0;
        win_hi_q[c]  <= '0;
        win_lo_q[c]  <= '0;
        cnt_q[c]     <= '0;
        los_cnt_q[c] <= LOS_MAX;
      end
    end else begin
      rx_hi_q <= rx_hi_d;
      rx_lo_q <= rx_lo_d;
      conf_q  <= conf_d;
      viol_q  <= viol_d;
      los_q   <= los_d;
      for (int c = 0; c < NUM_CH; c++) begin
        sync_hi_q[c] <= sync_hi_d[c];
        sync_lo_q[c] <= sync_lo_d[c];
        win_hi_q[c]  <= win_hi_d[c];
        win_lo_q[c]  <= win_lo_d[c];
        cnt_q[c]     <= cnt_d[c];
        los_cnt_q[c] <= los_cnt_d[c];
      end
    end
  end

  always_comb begin
    viol_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) viol_cnt[8*c +: 8] = cnt_q[c];
  end

  assign rx_hi = rx_hi_q;
  assign rx_lo = rx_lo_q;
  assign viol  = viol_q;
  assign los   = los_q;

endmodule

// File: tb/tb_e1_rx_phy_mc.sv
// Self-checking bench for e1_rx_phy_mc: four channels, LOS threshold of 10,
// default synchroniser and filter depths.
module tb_e1_rx_phy_mc;

  localparam int NCH = 4;
  localparam int LT  = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       pad_rx_hi, pad_rx_lo, viol_clr;
  logic [NCH-1:0]       rx_hi, rx_lo, viol, los;
  logic [8*NCH-1:0]     viol_cnt;

  e1_rx_phy_mc #(
    .NUM_CH(NCH), .SYNC_STAGES(2), .FILT_TAPS(3), .LOS_THRESH(LT)
  ) dut (
    .clk(clk), .rst(rst),
    .pad_rx_hi(pad_rx_hi), .pad_rx_lo(pad_rx_lo),
    .rx_hi(rx_hi), .rx_lo(rx_lo), .viol(viol),
    .viol_cnt(viol_cnt), .viol_clr(viol_clr), .los(los)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]   hi, lo, vv, ls;
    logic [8*NCH-1:0] cnt;
  } exp_t;

  typedef struct {
    logic             r;
    logic [NCH-1:0]   hi, lo, clr;
    int               n;
    logic [NCH-1:0]   x_los;
    logic [8*NCH-1:0] x_cnt;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[13];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: output after edge n is the majority of the pad samples
  // taken at edges n-3, n-4, n-5; a reset edge discards every earlier sample.
  logic [5:0]     h_hi [NCH];
  logic [5:0]     h_lo [NCH];
  logic [NCH-1:0] m_hi, m_lo, m_viol, m_conf, m_los;
  logic [7:0]     m_cnt [NCH];
  int             m_los_cnt [NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [NCH-1:0] hi, lo, clr, output exp_t e);
    logic mark, fh, fl, cf;
    for (int c = 0; c < NCH; c++) begin
      if (r) begin
        h_hi[c] = '0; h_lo[c] = '0;
        m_hi[c] = 1'b0; m_lo[c] = 1'b0; m_viol[c] = 1'b0; m_conf[c] = 1'b0;
        m_cnt[c] = '0; m_los_cnt[c] = LT; m_los[c] = 1'b1;
      end else begin
        mark = m_hi[c] | m_lo[c];
        if (clr[c])                          m_cnt[c] = m_viol[c] ? 8'd1 : 8'd0;
        else if (m_viol[c] && m_cnt[c] != 8'd255) m_cnt[c] = m_cnt[c] + 8'd1;
        if (mark)                m_los_cnt[c] = 0;
        else if (m_los_cnt[c] < LT) m_los_cnt[c] = m_los_cnt[c] + 1;
        m_los[c] = (m_los_cnt[c] == LT);
        h_hi[c] = {h_hi[c][4:0], hi[c]};
        h_lo[c] = {h_lo[c][4:0], lo[c]};
        fh = (int'(h_hi[c][3]) + int'(h_hi[c][4]) + int'(h_hi[c][5])) >= 2;
        fl = (int'(h_lo[c][3]) + int'(h_lo[c][4]) + int'(h_lo[c][5])) >= 2;
        cf = fh & fl;
        m_viol[c] = cf & ~m_conf[c];
        m_conf[c] = cf;
        m_hi[c]   = fh & ~fl;
        m_lo[c]   = fl & ~fh;
      end
      e.cnt[8*c +: 8] = m_cnt[c];
    end
    e.hi = m_hi; e.lo = m_lo; e.vv = m_viol; e.ls = m_los;
  endtask

  // Drive one sampling edge, queue the expected result, then compare after the edge.
  task automatic step(input logic r, input logic [NCH-1:0] hi, lo, clr);
    exp_t e, got;
    rst = r; pad_rx_hi = hi; pad_rx_lo = lo; viol_clr = clr;
    model_edge(r, hi, lo, clr, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("rx_hi", rx_hi, got.hi);
    check("rx_lo", rx_lo, got.lo);
    check("viol", viol, got.vv);
    check("los", los, got.ls);
    check("viol_cnt", viol_cnt, got.cnt);
  endtask

  initial begin
    rst = 1'b1; pad_rx_hi = '0; pad_rx_lo = '0; viol_clr = '0;
    for (int c = 0; c < NCH; c++) begin
      h_hi[c] = '0; h_lo[c] = '0; m_cnt[c] = '0; m_los_cnt[c] = LT;
    end
    m_hi = '0; m_lo = '0; m_viol = '0; m_conf = '0; m_los = '1;

    //            rst   hi       lo       clr      n   los      viol_cnt
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 3,  4'b1111, 32'h0000_0000};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 12, 4'b1111, 32'h0000_0000};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1,  4'b1111, 32'h0000_0000};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8,  4'b1111, 32'h0000_0000};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 1,  4'b1111, 32'h0000_0000};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8,  4'b1111, 32'h0000_0000};
    tbl[6]  = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 5,  4'b1111, 32'h0000_0000};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 10, 4'b1111, 32'h0000_0100};
    tbl[8]  = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 6,  4'b0111, 32'h0000_0100};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 3,  4'b0111, 32'h0000_0100};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 13, 4'b1111, 32'h0000_0100};
    tbl[11] = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 2,  4'b1111, 32'h0000_0100};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 6,  4'b1111, 32'h0001_0100};

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].hi, tbl[i].lo, tbl[i].clr);
      check($sformatf("tbl%0d_los", i), los, tbl[i].x_los);
      check($sformatf("tbl%0d_viol_cnt", i), viol_cnt, tbl[i].x_cnt);
    end

    // Six-cycle mark on ch0: output window, los fall, and los return after ten idle cycles.
    for (int k = 0; k < 24; k++) begin
      step(1'b0, (k < 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000);
      check("mark_rx_hi_ch0", rx_hi[0], (k >= 4 && k <= 9));
      check("mark_rx_lo_ch0", rx_lo[0], 1'b0);
      check("mark_los_ch0", los[0], (k < 5 || k >= 20));
    end

    // ch1 already holds 1; a clear on the pulse cycle must leave exactly 1.
    for (int k = 0; k < 9; k++) begin
      step(1'b0, (k < 5) ? 4'b0010 : 4'b0000, (k < 5) ? 4'b0010 : 4'b0000,
           (k == 5) ? 4'b0010 : 4'b0000);
      if (k == 4) check("clr_viol_pulse_ch1", viol[1], 1'b1);
      if (k == 5) check("clr_with_viol_ch1", viol_cnt[15:8], 8'd1);
    end
    step(1'b0, 4'b0000, 4'b0000, 4'b0010);
    check("clr_alone_ch1", viol_cnt[15:8], 8'd0);

    // 300 separate conflict runs on ch1 saturate its counter at 255.
    for (int rep = 0; rep < 300; rep++) begin
      for (int k = 0; k < 10; k++)
        step(1'b0, (k < 5) ? 4'b0010 : 4'b0000, (k < 5) ? 4'b0010 : 4'b0000, 4'b0000);
      if (rep == 0) check("sat_first_run_ch1", viol_cnt[15:8], 8'd1);
    end
    check("sat_all_channels", viol_cnt, 32'h0001_FF00);

    // Reset in the middle of a ch2 pulse; other channels stay in LOS throughout.
    for (int k = 0; k < 20; k++) begin
      step((k == 5 || k == 6), (k <= 12) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000);
      check("rst_los_others", {los[3], los[1], los[0]}, 3'b111);
      check("rst_rx_hi_ch2", rx_hi[2], (k == 4 || (k >= 11 && k <= 16)));
      check("rst_los_ch2", los[2], (k < 12));
    end
    check("rst_viol_cnt_cleared", viol_cnt, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e1_rx_phy_mc.md
E1_RX_PHY_MC -- requirements
Module: e1_rx_phy_mc

Interface
REQ-001 Parameter NUM_CH, default 1: number of independent E1 receive channels (legal 1..4).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth per line (legal 2..3).
REQ-003 Parameter FILT_TAPS, default 3: majority-vote window length (legal 1, 3, 5).
REQ-004 Parameter LOS_THRESH, default 255: mark-free cycles before loss-of-signal (legal 1..65535).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pad_rx_hi  in  NUM_CH  raw positive-pulse line per channel, asynchronous to clk.
REQ-008 pad_rx_lo  in  NUM_CH  raw negative-pulse line per channel, asynchronous to clk.
REQ-009 rx_hi  out  NUM_CH  filtered positive pulse, registered.
REQ-010 rx_lo  out  NUM_CH  filtered negative pulse, registered.
REQ-011 viol  out  NUM_CH  one-cycle pulse per channel on start of a hi/lo conflict.
REQ-012 viol_cnt  out  8*NUM_CH  per-channel saturating conflict-event count; channel n at bits [8n+7:8n].
REQ-013 viol_clr  in  NUM_CH  per-channel synchronous clear of viol_cnt.
REQ-014 los  out  NUM_CH  per-channel loss-of-signal flag, registered.

Function
REQ-015 Each pad line SHALL pass through a SYNC_STAGES-deep flip-flop chain, then a FILT_TAPS-deep sample window.
REQ-016 Filtered level SHALL be the majority of the window (window value when FILT_TAPS=1).
REQ-017 Latency: a level first sampled at edge E0 and held stable SHALL appear on rx_hi/rx_lo after edge E0+SYNC_STAGES+(FILT_TAPS+1)/2 (defaults: E0+4).
REQ-018 Isolated glitches shorter than (FILT_TAPS+1)/2 cycles SHALL not reach rx_hi/rx_lo.
REQ-019 If filtered hi and lo are both 1, rx_hi and rx_lo SHALL both be driven 0 that cycle (conflict state).
REQ-020 viol SHALL be 1 for exactly the first output cycle of each contiguous conflict run, 0 otherwise.
REQ-021 viol_cnt SHALL increment by 1 on each viol pulse and saturate at 255.
REQ-022 viol_clr SHALL set viol_cnt to 0 next cycle; viol_clr coincident with viol SHALL yield 1.
REQ-023 Per channel, a 16-bit LOS counter SHALL increment each cycle rx_hi=rx_lo=0 (including conflict cycles), saturating at LOS_THRESH.
REQ-024 Any cycle with rx_hi=1 or rx_lo=1 SHALL clear the LOS counter to 0 and deassert los on the next edge.
REQ-025 los SHALL assert on the edge the counter reaches LOS_THRESH and remain set until a mark per REQ-024.
REQ-026 Channels SHALL be fully independent; activity on one SHALL not affect another's outputs.

Reset
REQ-027 While rst=1, on each edge: sync chains and windows 0, rx_hi=0, rx_lo=0, viol=0, viol_cnt=0, los=1, LOS counter=LOS_THRESH.
REQ-028 rst asserted mid-pulse or mid-conflict SHALL abort it; no viol pulse or counter change SHALL result from pre-reset samples.
REQ-029 After rst release, first valid rx_hi/rx_lo SHALL follow REQ-017 counting from first post-reset sampling edge.

Verification
REQ-030 Defaults, pad_rx_hi 0->1 held 6 cycles, first sampled at E0 -> rx_hi=1 from E0+4 for 6 cycles, rx_lo=0, los falls at E0+5.
REQ-031 Defaults, 1-cycle pad_rx_lo glitch -> rx_lo stays 0, los stays 1, viol_cnt=0.
REQ-032 Defaults, both pads high 5 cycles -> rx_hi=rx_lo=0, single viol pulse, viol_cnt=1; repeat 300 times -> viol_cnt=255.
REQ-033 LOS_THRESH=10, one mark then idle -> los=0 after mark, los=1 exactly 10 cycles after last rx_hi=1 cycle.
REQ-034 viol_clr on same cycle as viol pulse -> viol_cnt=1; viol_clr alone -> viol_cnt=0.
REQ-035 NUM_CH=4, traffic on channel 2 only, rst pulsed mid-pulse -> channels 0,1,3 los=1 throughout; channel 2 outputs 0, los=1 during reset, resume per REQ-029.
